// File: rtl/i2s_tx_frame_cntlr.sv
// I2S / left-justified / TDM transmit frame controller: turns serial-clock edge pulses into
// per-slot load, per-bit shift, word select / frame sync and a sticky underrun flag.
module i2s_tx_frame_cntlr #(
  parameter int DATA_WIDTH   = 16,
  parameter int SLOT_WIDTH   = 32,
  parameter int NUM_CHANNELS = 2,
  parameter int CW           = $clog2(NUM_CHANNELS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          edge_detected,
  input  logic          enable,
  input  logic          lj_mode,
  input  logic          sample_valid,
  input  logic          clr_underrun,
  output logic          load,
  output logic          load_zero,
  output logic          shift,
  output logic          ws,
  output logic [CW-1:0] channel,
  output logic          frame_start,
  output logic          underrun,
  output logic [1:0]    dbg_state
);

  localparam int            BW       = $clog2(SLOT_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(SLOT_WIDTH - 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CHANNELS - 1);
  localparam bit            TDM      = (NUM_CHANNELS > 2);

  if (DATA_WIDTH > SLOT_WIDTH || SLOT_WIDTH < 2 || NUM_CHANNELS < 2) begin : g_bad_params
    $error("i2s_tx_frame_cntlr: illegal DATA_WIDTH/SLOT_WIDTH/NUM_CHANNELS combination");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, ACTIVE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          lj_q, lj_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] slot_q, slot_d;
  logic          load_q, load_d, load_zero_q, load_zero_d, shift_q, shift_d;
  logic          ws_q, ws_d, frame_start_q, frame_start_d, underrun_q, underrun_d;
  logic [CW-1:0] channel_q, channel_d;

  logic [BW-1:0] cur_bit;
  logic [CW-1:0] cur_slot, next_slot;
  logic          last_bit, last_slot, set_underrun;

  // Sample handshake: a load pulse consumes the sample offered with sample_valid=1;
  // with sample_valid=0 the same load pulse carries load_zero and nothing is consumed.
  always_comb begin
    state_d       = state_q;
    lj_d          = lj_q;
    bit_cnt_d     = bit_cnt_q;
    slot_d        = slot_q;
    channel_d     = channel_q;
    ws_d          = ws_q;
    load_d        = 1'b0;
    load_zero_d   = 1'b0;
    shift_d       = 1'b0;
    frame_start_d = 1'b0;
    set_underrun  = 1'b0;
    cur_bit       = (state_q == SYNC) ? '0 : bit_cnt_q;
    cur_slot      = (state_q == SYNC) ? '0 : slot_q;
    last_bit      = (cur_bit == LAST_BIT);
    last_slot     = (cur_slot == LAST_CH);
    next_slot     = last_slot ? '0 : cur_slot + 1'b1;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = SYNC;
          lj_d    = lj_mode;
        end
      end
      SYNC, ACTIVE: begin
        if (edge_detected) begin
          state_d   = ACTIVE;
          bit_cnt_d = last_bit ? '0 : cur_bit + 1'b1;
          slot_d    = last_bit ? next_slot : cur_slot;
          if (cur_bit == '0) begin
            load_d        = 1'b1;
            load_zero_d   = !sample_valid;
            set_underrun  = !sample_valid;
            frame_start_d = (cur_slot == '0);
            channel_d     = cur_slot;
          end else begin
            shift_d = 1'b1;
          end
          // I2S moves ws one bit ahead of the slot it belongs to; LJ aligns it with the load.
          if (TDM) begin
            ws_d = lj_q ? ((cur_bit == '0) && (cur_slot == '0)) : (last_bit && last_slot);
          end else if (lj_q) begin
            if (cur_bit == '0) ws_d = cur_slot[0];
          end else if (last_bit) begin
            ws_d = next_slot[0];
          end
          if (last_bit && last_slot && !enable) begin
            state_d   = IDLE;
            ws_d      = 1'b0;
            channel_d = '0;
            bit_cnt_d = '0;
            slot_d    = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    underrun_d = set_underrun ? 1'b1 : (clr_underrun ? 1'b0 : underrun_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      lj_q          <= 1'b0;
      bit_cnt_q     <= '0;
      slot_q        <= '0;
      channel_q     <= '0;
      ws_q          <= 1'b0;
      load_q        <= 1'b0;
      load_zero_q   <= 1'b0;
      shift_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      lj_q          <= lj_d;
      bit_cnt_q     <= bit_cnt_d;
      slot_q        <= slot_d;
      channel_q     <= channel_d;
      ws_q          <= ws_d;
      load_q        <= load_d;
      load_zero_q   <= load_zero_d;
      shift_q       <= shift_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign load        = load_q;
  assign load_zero   = load_zero_q;
  assign shift       = shift_q;
  assign ws          = ws_q;
  assign channel     = channel_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_i2s_tx_frame_cntlr.sv
// Bench for i2s_tx_frame_cntlr: a stereo I2S instance and a 4-slot TDM instance share stimulus;
// an edge-count reference model queues the expected pulse per edge and monitors compare.
module tb_i2s_tx_frame_cntlr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic edge_detected = 1'b0, enable = 1'b0, lj_mode = 1'b0;
  logic sample_valid = 1'b1, clr_underrun = 1'b0;

  logic       s_load, s_load_zero, s_shift, s_ws, s_frame_start, s_underrun;
  logic [0:0] s_channel;
  logic [1:0] s_dbg;
  logic       t_load, t_load_zero, t_shift, t_ws, t_frame_start, t_underrun;
  logic [1:0] t_channel;
  logic [1:0] t_dbg;

  i2s_tx_frame_cntlr u_stereo (
    .clk(clk), .rst(rst), .edge_detected(edge_detected), .enable(enable), .lj_mode(lj_mode),
    .sample_valid(sample_valid), .clr_underrun(clr_underrun),
    .load(s_load), .load_zero(s_load_zero), .shift(s_shift), .ws(s_ws), .channel(s_channel),
    .frame_start(s_frame_start), .underrun(s_underrun), .dbg_state(s_dbg)
  );

  i2s_tx_frame_cntlr #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .NUM_CHANNELS(4)) u_tdm (
    .clk(clk), .rst(rst), .edge_detected(edge_detected), .enable(enable), .lj_mode(lj_mode),
    .sample_valid(sample_valid), .clr_underrun(clr_underrun),
    .load(t_load), .load_zero(t_load_zero), .shift(t_shift), .ws(t_ws), .channel(t_channel),
    .frame_start(t_frame_start), .underrun(t_underrun), .dbg_state(t_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- counters / check ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // record = {load, load_zero, shift, frame_start, ws, channel[1:0], underrun}
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int sw[2] = '{32, 16};
  int nc[2] = '{2, 4};
  bit run[2];
  int k[2];
  bit ljl[2];
  bit und[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      run[d] = 0; k[d] = 0; ljl[d] = 0; und[d] = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Inputs given here are the ones the DUT samples at the coming clock edge.
  task automatic model_step(input int d, input bit e, input bit en_i, input bit lj_i,
                            input bit sv_i, input bit clr_i);
    int fl, b, slot;
    bit ld, wsx, last, go_idle, set;
    logic [1:0] ch;
    logic [7:0] rec;
    if (rst) return;
    if (!run[d]) begin
      if (en_i) begin run[d] = 1; k[d] = 0; ljl[d] = lj_i; end
      if (clr_i) und[d] = 0;
    end else if (e) begin
      fl      = sw[d] * nc[d];
      b       = k[d] % sw[d];
      slot    = (k[d] / sw[d]) % nc[d];
      ld      = (b == 0);
      last    = (k[d] % fl == fl - 1);
      go_idle = last && !en_i;
      if (nc[d] == 2)
        wsx = ljl[d] ? (slot % 2 == 1) : ((((k[d] + 1) / sw[d]) % nc[d]) % 2 == 1);
      else
        wsx = ljl[d] ? (k[d] % fl == 0) : last;
      ch = 2'(slot);
      if (go_idle) begin wsx = 0; ch = 2'd0; end
      set   = ld && !sv_i;
      und[d] = set ? 1'b1 : (clr_i ? 1'b0 : und[d]);
      rec = {ld, set, !ld, (k[d] % fl == 0), wsx, ch, und[d]};
      if (d == 0) exp_q0.push_back(rec); else exp_q1.push_back(rec);
      k[d]++;
      if (go_idle) run[d] = 0;
    end else if (clr_i) begin
      und[d] = 0;
    end
  endtask

  // ---------------- driver ----------------
  bit en_v = 0, lj_v = 0, sv_v = 1, clr_v = 0;
  bit sv_rand = 0, clr_rand = 0, lj_rand = 0;

  task automatic cycle(input bit e);
    bit sv, clr, lj;
    @(posedge clk);
    #1;
    sv  = sv_rand ? ($urandom_range(0, 5) != 0) : sv_v;
    clr = clr_v || (clr_rand && ($urandom_range(0, 30) == 0));
    lj  = lj_rand ? 1'($urandom_range(0, 1)) : lj_v;
    clr_v = 0;
    edge_detected = e; enable = en_v; lj_mode = lj;
    sample_valid = sv; clr_underrun = clr;
    model_step(0, e, en_v, lj, sv, clr);
    model_step(1, e, en_v, lj, sv, clr);
  endtask

  task automatic edge_gap(input int gmin, input int gmax);
    int g;
    g = $urandom_range(gmin, gmax);
    cycle(1);
    repeat (g - 1) cycle(0);
  endtask

  // Advance until dut0's model is running and the next edge has index target (mod modv).
  task automatic run_to(input int modv, input int target, input int gmin, input int gmax);
    int guard;
    guard = 0;
    while (!(run[0] && (k[0] % modv == target)) && guard < 2000) begin
      edge_gap(gmin, gmax);
      guard++;
    end
    if (guard >= 2000) begin
      checks++; errors++;
      $display("FAIL run_to_timeout actual=%0d expected=%0d", k[0] % modv, target);
    end
  endtask

  task automatic wait_idle(input int gmin, input int gmax);
    int guard;
    guard = 0;
    while ((run[0] || run[1]) && guard < 500) begin
      edge_gap(gmin, gmax);
      guard++;
    end
    if (guard >= 500) begin
      checks++; errors++;
      $display("FAIL wait_idle_timeout actual=running expected=idle");
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_outs"}, {s_load, s_load_zero, s_shift, s_ws, s_channel, s_frame_start, s_underrun}, 0);
    check({tag, "_t_outs"}, {t_load, t_load_zero, t_shift, t_ws, t_channel, t_frame_start, t_underrun}, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [7:0] act, e;
    if (!rst) begin
      if (s_load || s_shift) begin
        act = {s_load, s_load_zero, s_shift, s_frame_start, s_ws, 1'b0, s_channel, s_underrun};
        if (exp_q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL stereo_spurious_pulse actual=%0h expected=none", act);
        end else begin
          e = exp_q0.pop_front();
          check("stereo_pulse", act, e);
        end
      end
      if (t_load || t_shift) begin
        act = {t_load, t_load_zero, t_shift, t_frame_start, t_ws, t_channel, t_underrun};
        if (exp_q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL tdm_spurious_pulse actual=%0h expected=none", act);
        end else begin
          e = exp_q1.pop_front();
          check("tdm_pulse", act, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset_s_state", s_dbg, 0);
    check("reset_t_state", t_dbg, 0);
    @(negedge clk);
    rst = 1'b0;

    // I2S, steady edges every 4 clk, always-valid samples; then enable dropped at edge 40
    en_v = 1; lj_v = 0; sv_v = 1;
    repeat (3 * 64) edge_gap(4, 4);
    run_to(64, 40, 4, 4);
    en_v = 0;
    wait_idle(4, 4);
    repeat (8) edge_gap(4, 4);
    check("idle_s_ws_ch", {s_ws, s_channel}, 0);
    check("idle_t_ws_ch", {t_ws, t_channel}, 0);

    // LJ with random spacing, random underruns/clears, lj_mode wiggled while running
    en_v = 1; lj_v = 1;
    cycle(0);
    lj_rand = 1; sv_rand = 1; clr_rand = 1;
    repeat (4 * 64) edge_gap(1, 5);
    run_to(64, 10, 1, 5);
    en_v = 0;
    run_to(64, 50, 1, 5);
    en_v = 1;
    run_to(64, 0, 1, 5);
    run_to(64, 40, 1, 5);
    en_v = 0;
    wait_idle(1, 5);
    lj_rand = 0; sv_rand = 0; clr_rand = 0;
    repeat (4) cycle(0);
    clr_v = 1;
    cycle(0);
    cycle(0);

    // I2S again: underrun with clear in the same cycle, then clear alone
    en_v = 1; lj_v = 0; sv_v = 1;
    repeat (40) edge_gap(2, 4);
    run_to(32, 0, 2, 4);
    sv_v = 0; clr_v = 1;
    edge_gap(4, 4);
    sv_v = 1;
    check("set_wins_s_underrun", s_underrun, 1);
    check("set_wins_t_underrun", t_underrun, 1);
    repeat (20) edge_gap(2, 4);
    check("held_s_underrun", s_underrun, 1);
    clr_v = 1;
    cycle(0);
    cycle(0);
    check("clr_s_underrun", s_underrun, 0);
    check("clr_t_underrun", t_underrun, 0);

    // asynchronous reset mid-slot while a shift pulse is on the outputs
    run_to(32, 10, 2, 4);
    cycle(1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    edge_detected = 0; enable = 0; en_v = 0;
    #1;
    check_all_zero("async_rst");
    repeat (3) cycle(0);
    @(negedge clk);
    rst = 1'b0;
    en_v = 1; lj_v = 0;
    cycle(0);
    repeat (2 * 64) edge_gap(2, 4);
    en_v = 0;
    wait_idle(2, 4);
    repeat (6) cycle(0);

    check("stereo_queue_drained", exp_q0.size(), 0);
    check("tdm_queue_drained", exp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
